tdm_demux_1x8: RTL and testbench
================================

TDM_DEMUX_1X8 -- requirements
Module: tdm_demux_1x8

Interface
REQ-001 The block SHALL have no parameters; lane count is fixed at 8, slot index is fixed at 3 bits.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 din  input  1  serial TDM data bit for the current slot.
REQ-005 din_valid  input  1  din is sampled on this edge when high.
REQ-006 frame_sync  input  1  marks the din_valid sample as slot 0 of a frame; ignored when din_valid is low.
REQ-007 q  output  8  last complete frame; q[n] = bit received in slot n.
REQ-008 frame_valid  output  1  one-cycle pulse: q was updated on this edge.
REQ-009 slot  output  3  slot index the next accepted sample will occupy.
REQ-010 locked  output  1  high in LOCKED state.
REQ-011 sync_err  output  1  one-cycle pulse: frame_sync arrived mid-frame.

Function
REQ-012 The block SHALL implement two states, HUNT and LOCKED.
REQ-013 In HUNT, samples with din_valid=1 and frame_sync=0 SHALL be discarded, with slot held at 0.
REQ-014 In HUNT, din_valid=1 with frame_sync=1 SHALL store din as shadow bit 0, set slot=1, and enter LOCKED.
REQ-015 In LOCKED, each din_valid=1 with frame_sync=0 SHALL store din in shadow bit [slot] and increment slot modulo 8.
REQ-016 In LOCKED, an accepted sample at slot 7 SHALL load q with {din, shadow[6:0]} and assert frame_valid for exactly the following cycle.
REQ-017 After REQ-016, slot SHALL wrap to 0 and the block SHALL remain LOCKED.
REQ-018 Latency: q and frame_valid SHALL become visible one clock edge after the slot-7 sample edge (registered outputs).
REQ-019 In LOCKED, din_valid=1, frame_sync=1 and slot=0 SHALL be a normal slot-0 sample with no error.
REQ-020 In LOCKED, din_valid=1, frame_sync=1 and slot!=0 SHALL:
  - pulse sync_err for one cycle;
  - discard the partial frame (q unchanged, no frame_valid);
  - store din as shadow bit 0 and set slot=1.
REQ-021 In LOCKED, frame_sync absent at slot 0 SHALL NOT be an error; the block SHALL free-run on its count.
REQ-022 din_valid=0 cycles SHALL leave slot, shadow, q and state unchanged, and frame_valid and sync_err SHALL be 0 in the cycle that follows.
REQ-023 Between frame_valid pulses, q SHALL hold its last value.
REQ-024 No combinational path SHALL exist from any input to any output.

Reset
REQ-025 When rst_n=0 at a rising edge, the following SHALL hold on the next cycle:
  - q=8'h00, frame_valid=0, sync_err=0;
  - slot=0, locked=0, state=HUNT;
  - shadow=8'h00.
REQ-026 Reset SHALL take priority over all other inputs.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no frame_valid pulse.
REQ-028 After rst_n returns to 1, the block SHALL require a new frame_sync to relock.

Verification
REQ-029 Reset then frame 8'b1010_1010 (slot0 first, frame_sync with slot0, 8 consecutive valids) -> frame_valid pulses once, 1 cycle after the 8th sample; q=8'hAA; locked=1.
REQ-030 Second frame 8'h5A sent without frame_sync, with din_valid gaps of 1-3 cycles inserted -> q=8'h5A after the last sample; no sync_err; slot sequence 0..7 then wrap to 0.
REQ-031 Five valid samples in HUNT without frame_sync -> slot stays 0, locked=0, no frame_valid.
REQ-032 LOCKED at slot=4, then frame_sync with din=1 -> sync_err pulses once; slot=1; q retains previous value; the subsequent 7 samples complete a frame with q[0]=1.
REQ-033 rst_n=0 for 1 cycle at slot=6 -> q=8'h00, locked=0, slot=0; the next 8 samples without frame_sync produce no frame_valid.
REQ-034 frame_sync=1 with din_valid=0 in HUNT and LOCKED -> no state change, no pulse.

Source files
------------

// File: rtl/tdm_demux_1x8.sv
// tdm_demux_1x8: 1-to-8 TDM demultiplexer with frame alignment.
//
// The block collects serial bits, one per valid sample, into an 8-bit shadow
// register. Each bit goes into the slot position the block currently expects.
// A frame_sync sample marks slot 0 and aligns the block to the frame. When the
// slot-7 sample arrives, the whole frame is published on q together with a
// one-cycle frame_valid pulse.
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst_n       in   synchronous active-low reset
//   din         in   serial data bit for the current slot
//   din_valid   in   din is sampled on this edge when high
//   frame_sync  in   marks the valid sample as slot 0 (ignored if !din_valid)
//   q[7:0]      out  last complete frame, q[n] = bit from slot n
//   frame_valid out  one-cycle pulse, q updated on this edge
//   slot[2:0]   out  slot the next accepted sample will occupy
//   locked      out  high while frame-aligned
//   sync_err    out  one-cycle pulse, frame_sync arrived mid-frame
//
// state  | meaning
// HUNT   | not aligned; discard samples until a frame_sync sample arrives
// LOCKED | aligned; samples fill shadow[slot], slot-7 sample publishes q

module tdm_demux_1x8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    input  logic       frame_sync,
    output logic [7:0] q,
    output logic       frame_valid,
    output logic [2:0] slot,
    output logic       locked,
    output logic       sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] slot_nxt;
    logic [7:0] shadow, shadow_nxt;
    logic [7:0] q_nxt;
    logic       frame_valid_nxt;
    logic       sync_err_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot        <= 3'd0;
            shadow      <= 8'h00;
            q           <= 8'h00;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            slot        <= slot_nxt;
            shadow      <= shadow_nxt;
            q           <= q_nxt;
            frame_valid <= frame_valid_nxt;
            sync_err    <= sync_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        slot_nxt        = slot;
        shadow_nxt      = shadow;
        q_nxt           = q;
        frame_valid_nxt = 1'b0;
        sync_err_nxt    = 1'b0;

        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_nxt[0] = din;
                        slot_nxt      = 3'd1;
                        state_nxt     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync && (slot != 3'd0)) begin
                        // Realign on the new frame start. The stale bits in
                        // shadow[7:1] are overwritten before they are published.
                        sync_err_nxt  = 1'b1;
                        shadow_nxt[0] = din;
                        slot_nxt      = 3'd1;
                    end else begin
                        shadow_nxt[slot] = din;
                        // The slot counter wraps 7 -> 0 by its natural overflow.
                        slot_nxt         = slot + 3'd1;
                        if (slot == 3'd7) begin
                            q_nxt           = {din, shadow[6:0]};
                            frame_valid_nxt = 1'b1;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Testbench for tdm_demux_1x8: directed stimulus plus a scoreboard. The
// stimulus process pushes each expected frame and sync_err pulse into a queue.
// A negedge monitor pops an entry from the matching queue whenever the DUT
// pulses, and compares it.

module tb_tdm_demux_1x8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       din_valid;
    logic       frame_sync;
    logic [7:0] q;
    logic       frame_valid;
    logic [2:0] slot;
    logic       locked;
    logic       sync_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_frames[$];
    int         exp_errs[$];

    always #5 clk = ~clk;

    tdm_demux_1x8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .q          (q),
        .frame_valid(frame_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One accepted sample. Returns #1 after the sampling edge, so the
    // registered outputs from that edge are visible.
    task automatic smp(input logic b, input logic fs);
        din        = b;
        frame_sync = fs;
        din_valid  = 1'b1;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (frame_valid) begin
            if (exp_frames.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame_valid: got q=%0h expected no pulse at %0t", q, $time);
            end else begin
                check("frame_q", q, exp_frames.pop_front());
            end
        end
        if (sync_err) begin
            if (exp_errs.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sync_err: got 1 expected 0 at %0t", $time);
            end else begin
                void'(exp_errs.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        int         gaps[8];
        gaps = '{1, 2, 3, 1, 2, 3, 1, 2};

        // The resets below are asserted while the other inputs are active, so
        // reset has to win over them.
        rst_n      = 1'b0;
        din        = 1'b1;
        din_valid  = 1'b1;
        frame_sync = 1'b1;
        idle(2);
        rst_n      = 1'b1;
        din        = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        check("rst_q", q, 8'h00);
        check("rst_slot", slot, 0);
        check("rst_locked", locked, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_se", sync_err, 0);

        // Five samples in HUNT without frame_sync
        for (int i = 0; i < 5; i++) begin
            smp(i[0], 1'b0);
            check("hunt_slot", slot, 0);
        end
        check("hunt_locked", locked, 0);

        // frame_sync without din_valid while in HUNT
        frame_sync = 1'b1;
        din        = 1'b1;
        idle(1);
        frame_sync = 1'b0;
        din        = 1'b0;
        check("hunt_fs_nv_locked", locked, 0);
        check("hunt_fs_nv_slot", slot, 0);

        // Frame 8'hAA, frame_sync with slot 0, back-to-back samples
        v = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_frames.push_back(8'hAA);
            smp(v[i], i == 0);
            check("aa_slot", slot, (i + 1) % 8);
        end
        check("aa_fv_pulse", frame_valid, 1);
        check("aa_locked", locked, 1);
        idle(1);
        check("aa_fv_one_cycle", frame_valid, 0);
        check("aa_q_hold", q, 8'hAA);

        // Frame 8'h5A free-running with gaps between the samples
        v = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_frames.push_back(8'h5A);
            smp(v[i], 1'b0);
            check("5a_slot", slot, (i + 1) % 8);
            idle(gaps[i]);
            check("5a_slot_gap", slot, (i + 1) % 8);
            if (i < 7) check("5a_q_hold", q, 8'hAA);
        end
        check("5a_q", q, 8'h5A);

        // frame_sync without din_valid while LOCKED
        smp(1'b1, 1'b0);
        smp(1'b0, 1'b0);
        frame_sync = 1'b1;
        din        = 1'b1;
        idle(1);
        frame_sync = 1'b0;
        din        = 1'b0;
        check("lk_fs_nv_slot", slot, 2);
        check("lk_fs_nv_locked", locked, 1);
        check("lk_fs_nv_se", sync_err, 0);

        // Reach slot 4, then a mid-frame frame_sync with din=1
        smp(1'b1, 1'b0);
        smp(1'b1, 1'b0);
        check("pre_err_slot", slot, 4);
        exp_errs.push_back(1);
        smp(1'b1, 1'b1);
        check("err_pulse", sync_err, 1);
        check("err_slot", slot, 1);
        check("err_q_hold", q, 8'h5A);
        check("err_locked", locked, 1);
        idle(1);
        check("err_one_cycle", sync_err, 0);
        v = 8'hC3;
        for (int i = 1; i < 8; i++) begin
            if (i == 7) exp_frames.push_back(8'hC3);
            smp(v[i], 1'b0);
        end
        check("c3_q", q, 8'hC3);

        // frame_sync arriving at slot 0 is a normal sample
        v = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_frames.push_back(8'h3C);
            smp(v[i], i == 0);
        end
        check("3c_q", q, 8'h3C);

        // Reset at slot 6, then samples without frame_sync must not relock
        for (int i = 0; i < 6; i++) smp(1'b1, 1'b0);
        check("pre_rst_slot", slot, 6);
        rst_n     = 1'b0;
        din_valid = 1'b1;
        din       = 1'b1;
        idle(1);
        rst_n     = 1'b1;
        din_valid = 1'b0;
        din       = 1'b0;
        check("mid_rst_q", q, 8'h00);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_slot", slot, 0);
        for (int i = 0; i < 8; i++) smp(1'b1, 1'b0);
        check("post_rst_locked", locked, 0);
        check("post_rst_slot", slot, 0);
        check("post_rst_q", q, 8'h00);

        idle(3);
        check("frames_outstanding", exp_frames.size(), 0);
        check("errs_outstanding", exp_errs.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
